// File: rtl/mul_result_drain_pkg.sv
// Shared types and constants for the Booth multiplier result drain.
package mul_pkg;

  localparam int PROD_W   = 67;  // {a[33:0], q[32:0]}
  localparam int WORD_W   = 32;  // output stream word width
  localparam int A_MSB    = 66;  // top bit of the product bus
  localparam int RES_MSB  = 63;  // top bit of the signed 64-bit result
  localparam int WAIT_MAX = 64;  // default completion timeout in WAIT cycles

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    SETTLE  = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4
  } state_e;

  // The result fits 64-bit signed only when bits [66:63] are all equal
  // (pure sign extension of bit 63).
  function automatic logic sext_ovf(input logic [3:0] top);
    return ~(&top | ~|top);
  endfunction

endpackage

// File: rtl/mul_timeout_ctr.sv
// Completion timer: cleared by load_i, counts enabled cycles, and flags
// the enabled cycle on which the LIMIT-th count is reached.
module mul_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This enabled cycle brings the count to LIMIT.
  assign hit_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mul_result_drain.sv
// Drains the Booth multiplier: waits for completion, captures the product
// one cycle after the done pulse, and streams the signed 64-bit result as
// two 32-bit words (low, then high) with overflow and timeout flags.
//
// Handshake: a word transfers on a rising clk edge where out_valid_o and
// out_ready_i are both 1. Once out_valid_o is raised it stays high, and
// out_data_o / out_last_o / out_ovf_o / out_tmo_o stay stable, until that
// transfer happens.
module mul_result_drain
  import mul_pkg::*;
#(
  parameter int PROD_W   = mul_pkg::PROD_W,
  parameter int WORD_W   = mul_pkg::WORD_W,
  parameter int WAIT_MAX = mul_pkg::WAIT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mul_done_i,
  input  logic [PROD_W-1:0] product_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_ovf_o,
  output logic              out_tmo_o,
  output logic              busy_o,
  output logic [2:0]        state_dbg_o
);

  localparam int RES_W = 2 * WORD_W;

  state_e             state_q, state_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_hit;

  mul_timeout_ctr #(
    .LIMIT (WAIT_MAX)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .hit_o  (tmr_hit)
  );

  // Next state, capture register and timer control.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          res_d    = '0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        // A done pulse on the limit cycle beats the timeout.
        if (mul_done_i) begin
          state_d = SETTLE;
        end else if (tmr_hit) begin
          state_d = SEND_LO;
          res_d   = '0;
          tmo_d   = 1'b1;
        end
      end
      SETTLE: begin
        // The product register updates the cycle after the done pulse.
        res_d   = product_i[RES_W-1:0];
        ovf_d   = sext_ovf(product_i[PROD_W-1:RES_W-1]);
        state_d = SEND_LO;
      end
      SEND_LO: begin
        if (out_ready_i) begin
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // Output mux: words and flags only while a word is being offered.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    out_ovf_o   = 1'b0;
    out_tmo_o   = 1'b0;
    if (state_q == SEND_LO) begin
      out_valid_o = 1'b1;
      out_data_o  = res_q[WORD_W-1:0];
      out_ovf_o   = ovf_q;
      out_tmo_o   = tmo_q;
    end else if (state_q == SEND_HI) begin
      out_valid_o = 1'b1;
      out_data_o  = res_q[RES_W-1:WORD_W];
      out_last_o  = 1'b1;
      out_ovf_o   = ovf_q;
      out_tmo_o   = tmo_q;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mul_result_drain.sv
// Directed bench for mul_result_drain.
module tb_mul_result_drain;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mul_done_i;
  logic [66:0] product_i;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_ovf_o;
  logic        out_tmo_o;
  logic        busy_o;
  logic [2:0]  state_dbg_o;

  int checks = 0;
  int errors = 0;

  mul_result_drain dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .mul_done_i  (mul_done_i),
    .product_i   (product_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ovf_o   (out_ovf_o),
    .out_tmo_o   (out_tmo_o),
    .busy_o      (busy_o),
    .state_dbg_o (state_dbg_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a multiply and pulse done on the delay-th WAIT cycle. The product
  // bus carries a decoy during the done cycle and the real value afterwards.
  // Returns with the DUT expected to be in SEND_LO.
  task automatic mul_op(input string tag, input int delay, input logic [66:0] prod);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, " busy_after_start"}, busy_o, 1);
    check({tag, " state_wait"}, state_dbg_o, 1);
    repeat (delay - 1) tick();
    check({tag, " no_valid_in_wait"}, out_valid_o, 0);
    mul_done_i = 1'b1;
    product_i  = ~prod;
    tick();
    mul_done_i = 1'b0;
    product_i  = prod;
    check({tag, " settle_no_valid"}, out_valid_o, 0);
    tick();
    product_i  = '0;
    check({tag, " valid_latency"}, out_valid_o, 1);
  endtask

  // Check one offered word, then let it transfer (out_ready_i must be 1).
  task automatic recv_word(input string tag, input logic [31:0] data, input logic last,
                           input logic ovf, input logic tmo);
    check({tag, " valid"}, out_valid_o, 1);
    check({tag, " data"},  out_data_o, data);
    check({tag, " last"},  out_last_o, last);
    check({tag, " ovf"},   out_ovf_o, ovf);
    check({tag, " tmo"},   out_tmo_o, tmo);
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    start_i     = 1'b0;
    mul_done_i  = 1'b0;
    product_i   = '0;
    out_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst valid", out_valid_o, 0);
    check("rst data",  out_data_o, 0);
    check("rst last",  out_last_o, 0);
    check("rst ovf",   out_ovf_o, 0);
    check("rst tmo",   out_tmo_o, 0);
    check("rst busy",  busy_o, 0);
    check("rst state", state_dbg_o, 0);

    // 1: 172*172 after 40 cycles
    mul_op("t1", 40, 67'h7390);
    recv_word("t1 lo", 32'h0000_7390, 1'b0, 1'b0, 1'b0);
    recv_word("t1 hi", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check("t1 idle busy",  busy_o, 0);
    check("t1 idle valid", out_valid_o, 0);

    // 2: result -1
    mul_op("t2", 5, 67'h7_FFFF_FFFF_FFFF_FFFF);
    recv_word("t2 lo", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    recv_word("t2 hi", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // 3: top bits 0100 overflow
    mul_op("t3", 3, 67'h2_0000_0000_1234_5678);
    recv_word("t3 lo", 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    recv_word("t3 hi", 32'h0000_0000, 1'b1, 1'b1, 1'b0);

    // 4: backpressure for 5 cycles in SEND_LO
    out_ready_i = 1'b0;
    mul_op("t4", 7, 67'h0_0000_00AB_CDEF_0123);
    for (int i = 0; i < 5; i++) begin
      check("t4 hold valid", out_valid_o, 1);
      check("t4 hold data",  out_data_o, 32'hCDEF_0123);
      check("t4 hold last",  out_last_o, 0);
      tick();
    end
    out_ready_i = 1'b1;
    recv_word("t4 lo", 32'hCDEF_0123, 1'b0, 1'b0, 1'b0);
    recv_word("t4 hi", 32'h0000_00AB, 1'b1, 1'b0, 1'b0);

    // 5: timeout after 64 WAIT cycles
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (63) tick();
    check("t5 last wait valid", out_valid_o, 0);
    check("t5 last wait busy",  busy_o, 1);
    tick();
    recv_word("t5 lo", 32'h0, 1'b0, 1'b0, 1'b1);
    check("t5 busy in hi", busy_o, 1);
    recv_word("t5 hi", 32'h0, 1'b1, 1'b0, 1'b1);
    check("t5 busy after", busy_o, 0);

    // Done on the limit cycle wins over timeout; start during final handshake ignored
    mul_op("t5b", 64, 67'h7_FFFF_FFFF_8000_0000);
    recv_word("t5b lo", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    recv_word("t5b hi", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    start_i = 1'b0;
    check("t5b start ignored busy", busy_o, 0);
    tick();
    check("t5b still idle", busy_o, 0);

    // 6: reset in SEND_HI, then spurious done in IDLE
    mul_op("t6", 4, 67'h2_0000_0000_0000_0001);
    recv_word("t6 lo", 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    out_ready_i = 1'b0;
    check("t6 in hi last", out_last_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 rst valid", out_valid_o, 0);
    check("t6 rst busy",  busy_o, 0);
    check("t6 rst ovf",   out_ovf_o, 0);
    check("t6 rst data",  out_data_o, 0);
    mul_done_i = 1'b1;
    product_i  = 67'h1234;
    tick();
    mul_done_i = 1'b0;
    tick();
    tick();
    check("t6 spurious valid", out_valid_o, 0);
    check("t6 spurious busy",  busy_o, 0);
    check("t6 spurious state", state_dbg_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
